// File: rtl/cell_mem_seq.sv
// rtl/cell_mem_seq.sv - LSTM cell-state memory sequencer: timestep-major forward writes,
// reverse-timestep (c_t, c_{t-1}) replay through a 2-entry valid/ready output buffer.
module cell_mem_seq #(
    parameter int WIDTH      = 32,
    parameter int NUM        = 53,
    parameter int TIMESTEP   = 8,
    parameter int ADDR_WIDTH = 12,
    localparam int T_W = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1,
    localparam int N_W = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  i_ready,
    input  logic                  bwd_start,
    output logic                  mem_wr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_a,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [WIDTH-1:0]      mem_i_a,
    input  logic [WIDTH-1:0]      mem_o_a,
    input  logic [WIDTH-1:0]      mem_o_b,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [WIDTH-1:0]      o_ct,
    output logic [WIDTH-1:0]      o_ct_prev,
    output logic [T_W-1:0]        o_t,
    output logic [N_W-1:0]        o_n,
    output logic                  fwd_done,
    output logic                  bwd_done
);

    typedef enum logic [1:0] {S_FWD, S_FULL, S_BWD} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM * TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0] NUM_A     = ADDR_WIDTH'(NUM);
    localparam logic [ADDR_WIDTH-1:0] TOP_BASE  = ADDR_WIDTH'((TIMESTEP - 1) * NUM);
    localparam logic [T_W-1:0]        T_LAST    = T_W'(TIMESTEP - 1);
    localparam logic [N_W-1:0]        N_LAST    = N_W'(NUM - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wcnt;
    logic                  r_fwd_done;
    logic                  r_bwd_done;

    // Read issue counters; r_base tracks r_rt*NUM so no multiplier is needed.
    logic [T_W-1:0]        r_rt;
    logic [N_W-1:0]        r_rn;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_issue_done;

    logic                  r_inflight;
    logic [T_W-1:0]        r_inf_t;
    logic [N_W-1:0]        r_inf_n;

    logic [WIDTH-1:0]      r_buf_ct   [2];
    logic [WIDTH-1:0]      r_buf_prev [2];
    logic [T_W-1:0]        r_buf_t    [2];
    logic [N_W-1:0]        r_buf_n    [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_wr;
    logic                  w_last_wr;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_last_pop;
    logic                  w_start;

    always_comb begin
        w_wr         = (r_state == S_FWD) && i_valid;
        w_last_wr    = w_wr && (r_wcnt == LAST_ADDR);
        w_valid      = (r_count != 2'd0);
        w_pop        = w_valid && o_ready;
        w_push       = r_inflight;
        // Occupancy after this cycle's pop; a read is only issued if its data is guaranteed a slot.
        w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
        w_issue      = (r_state == S_BWD) && !r_issue_done && (w_occ < 3'd2);
        w_last_issue = w_issue && (r_rt == '0) && (r_rn == N_LAST);
        w_last_pop   = w_pop && (r_buf_t[r_rd_ptr] == '0) && (r_buf_n[r_rd_ptr] == N_LAST);
        w_start      = (r_state == S_FULL) && bwd_start;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FWD:   if (w_last_wr)  w_state_nxt = S_FULL;
            S_FULL:  if (w_start)    w_state_nxt = S_BWD;
            S_BWD:   if (w_last_pop) w_state_nxt = S_FWD;
            default: w_state_nxt = S_FWD;
        endcase
    end

    always_comb begin
        i_ready    = (r_state == S_FWD);
        mem_wr_a   = w_wr;
        mem_i_a    = i_data;
        mem_addr_b = r_base + ADDR_WIDTH'(r_rn);
        if (r_state == S_BWD) begin
            mem_addr_a = (r_rt != '0) ? (r_base - NUM_A + ADDR_WIDTH'(r_rn)) : '0;
        end else begin
            mem_addr_a = r_wcnt;
        end
        o_valid   = w_valid;
        o_ct      = w_valid ? r_buf_ct[r_rd_ptr]   : '0;
        o_ct_prev = w_valid ? r_buf_prev[r_rd_ptr] : '0;
        o_t       = w_valid ? r_buf_t[r_rd_ptr]    : '0;
        o_n       = w_valid ? r_buf_n[r_rd_ptr]    : '0;
        fwd_done  = r_fwd_done;
        bwd_done  = r_bwd_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FWD;
            r_wcnt       <= '0;
            r_fwd_done   <= 1'b0;
            r_bwd_done   <= 1'b0;
            r_rt         <= '0;
            r_rn         <= '0;
            r_base       <= '0;
            r_issue_done <= 1'b0;
            r_inflight   <= 1'b0;
            r_inf_t      <= '0;
            r_inf_n      <= '0;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_buf_ct[i]   <= '0;
                r_buf_prev[i] <= '0;
                r_buf_t[i]    <= '0;
                r_buf_n[i]    <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_fwd_done <= w_last_wr;
            r_bwd_done <= w_last_pop;

            if (w_wr) begin
                r_wcnt <= w_last_wr ? '0 : r_wcnt + ADDR_WIDTH'(1);
            end

            if (w_start) begin
                r_rt         <= T_LAST;
                r_rn         <= '0;
                r_base       <= TOP_BASE;
                r_issue_done <= 1'b0;
            end else if (w_last_pop) begin
                r_rt         <= '0;
                r_rn         <= '0;
                r_base       <= '0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                if (w_last_issue) begin
                    r_issue_done <= 1'b1;
                end else if (r_rn == N_LAST) begin
                    r_rn   <= '0;
                    r_rt   <= r_rt - T_W'(1);
                    r_base <= r_base - NUM_A;
                end else begin
                    r_rn <= r_rn + N_W'(1);
                end
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_t <= r_rt;
                r_inf_n <= r_rn;
            end

            // Timestep 0 has no predecessor: its port-A read of address 0 is discarded.
            if (w_push) begin
                r_buf_ct[r_wr_ptr]   <= mem_o_b;
                r_buf_prev[r_wr_ptr] <= (r_inf_t == '0) ? '0 : mem_o_a;
                r_buf_t[r_wr_ptr]    <= r_inf_t;
                r_buf_n[r_wr_ptr]    <= r_inf_n;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/cell_mem_seq.md
Name: cell_mem_seq

Overview:
- Address sequencer and stream adapter sitting directly in front of the LSTM cell-state memory (dual-port RAM: 1-cycle registered read on both ports, write via port A).
- Forward phase: accepts the forward unit's cell-state stream and writes it timestep-major into the memory.
- Backward phase: on request, replays pairs (c_t, c_{t-1}) in reverse timestep order to the BPTT unit over a valid/ready stream with a 2-entry output buffer.

Parameters:
- WIDTH, 32, data width (signed).
- NUM, 53, cell-state elements per timestep.
- TIMESTEP, 8, timesteps stored; NUM*TIMESTEP must be <= 2^ADDR_WIDTH.
- ADDR_WIDTH, 12, memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  forward stream element valid.
- i_data  in  WIDTH  forward cell-state element.
- i_ready  out  1  block accepts i_data this cycle.
- bwd_start  in  1  single-cycle request to begin backward replay.
- mem_wr_a  out  1  memory port-A write enable.
- mem_addr_a  out  ADDR_WIDTH  port-A address: write address in forward phase, c_{t-1} read address in backward phase.
- mem_addr_b  out  ADDR_WIDTH  port-B read address (c_t).
- mem_i_a  out  WIDTH  port-A write data.
- mem_o_a  in  WIDTH  port-A read data, valid the cycle after its address.
- mem_o_b  in  WIDTH  port-B read data, valid the cycle after its address.
- o_valid  out  1  backward output pair valid.
- o_ready  in  1  downstream accepts pair.
- o_ct  out  WIDTH  c_t.
- o_ct_prev  out  WIDTH  c_{t-1}; 0 when t==0.
- o_t  out  clog2(TIMESTEP)  timestep of the current pair.
- o_n  out  clog2(NUM)  element index of the current pair.
- fwd_done  out  1  one-cycle pulse after the last forward write.
- bwd_done  out  1  one-cycle pulse on acceptance of the last pair.

Behaviour:
- **States:** S_FWD, S_FULL, S_BWD.
- **Reset:**
  - state=S_FWD; all counters 0; buffer empty.
  - o_valid, o_ct, o_ct_prev, o_t, o_n, fwd_done, bwd_done, mem_wr_a = 0.
  - i_ready=1.
  - Memory contents untouched.
  - Reset mid-operation aborts the phase in progress; no done pulse is produced.
- **S_FWD:**
  - i_ready=1.
  - On i_valid: mem_wr_a=1 combinationally, mem_addr_a=wcnt, mem_i_a=i_data; wcnt++.
  - Address order is addr = t*NUM + n, n fastest.
  - On the write at wcnt==NUM*TIMESTEP-1: fwd_done=1 next cycle, state -> S_FULL, wcnt -> 0.
  - bwd_start is ignored in S_FWD.
- **S_FULL:**
  - i_ready=0; i_valid is ignored.
  - bwd_start -> S_BWD, with read counters t=TIMESTEP-1, n=0.
- **S_BWD read issue:**
  - One read per cycle when (buffer_count + inflight - pop) < 2, where pop = o_valid & o_ready.
  - mem_addr_b = t*NUM + n.
  - mem_addr_a = (t-1)*NUM + n if t>0, else 0 with c_{t-1} forced to 0.
  - n increments; on wrap n=NUM-1 -> 0, t decrements.
  - Issue stops after the pair (t=0, n=NUM-1).
- **Read return and buffering:**
  - Read data returns the next cycle and is pushed into a 2-entry FIFO together with its t/n tags.
  - Outputs come from the FIFO head.
- **Latency and throughput:**
  - bwd_start sampled at edge k: first read issued in cycle k+1, o_valid first high in cycle k+3.
  - With o_ready held high: one pair per cycle, no bubbles.
- **Output handshake:**
  - While o_valid=1 and o_ready=0: o_ct, o_ct_prev, o_t and o_n hold stable.
  - No pair is lost or duplicated.
- **Completion:** pop of the last pair -> bwd_done=1 next cycle, state -> S_FWD, counters 0, ready for the next sequence. bwd_start is ignored outside S_FULL.
- **Port usage:** mem_wr_a is never asserted outside S_FWD. Port A never reads and writes in the same cycle.
- **Arithmetic:** address products computed at ADDR_WIDTH without sign; data passes through unmodified.

Test Plan:
- NUM=3, TIMESTEP=2: stream 0x10..0x15 with i_valid=1 -> writes to addrs 0..5 in order, fwd_done pulses once the cycle after the 6th write, then i_ready=0.
- Same setup, bwd_start, o_ready=1 -> (o_t, o_n, o_ct, o_ct_prev) sequence:
  - (1,0,0x13,0x10), (1,1,0x14,0x11), (1,2,0x15,0x12)
  - (0,0,0x10,0), (0,1,0x11,0), (0,2,0x12,0)
  - o_valid first high 3 cycles after bwd_start, 6 consecutive cycles; bwd_done after the last.
- Backpressure: o_ready low for 5 cycles after the 2nd pair -> outputs hold at pair 3, no issue beyond buffer capacity, full sequence is still exactly the 6 pairs above.
- Random o_ready (50%) over a NUM=53, TIMESTEP=8 replay -> scoreboard matches all 424 pairs in reverse-timestep order.
- bwd_start pulsed during S_FWD after 2 writes -> ignored; wcnt continues; i_valid during S_FULL -> no mem_wr_a.
- rst asserted mid-S_BWD after 2 pairs -> o_valid=0 immediately; state S_FWD with i_ready=1; no bwd_done; the next forward stream writes from addr 0.
